// File: rtl/lsu.sv
// Load/store unit: req/gnt/rvalid data-memory port, load extension, timeout and illegal-op reporting.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error completions.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_we,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic        wb_err,
    output logic        misalign
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_err_q, wb_err_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   wb_rdata_q, wb_rdata_d;

    logic          ex_illegal, ex_misal;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    // Stores allow only 000/001/010; loads reject 011, 110, 111.
    always_comb begin
        if (ex_we) begin
            ex_illegal = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
        end else begin
            ex_illegal = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign ex_misal = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
`else
    assign ex_misal = 1'b0;
`endif

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
            misalign_q <= 1'b0;
            wb_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_err_q   <= wb_err_d;
            misalign_q <= misalign_d;
            wb_rdata_q <= wb_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 1'b1;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_err_d   = 1'b0;
        misalign_d = 1'b0;
        wb_rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ex_valid) begin
                    we_d    = ex_we;
                    f3_d    = ex_funct3;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    if (ex_illegal || ex_misal) begin
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        misalign_d = ex_misal && !ex_illegal;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rdata_d = we_q ? 32'd0 : ld_ext;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIM) begin
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus fields are driven only while requesting so they read as zero otherwise.
    always_comb begin
        ex_ready  = (state_q == S_IDLE);
        stall     = (state_q != S_IDLE);
        mem_req   = (state_q == S_REQ);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr = {addr_q[31:2], 2'b00};
            mem_we   = we_q;
            case (f3_q[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
        wb_valid = wb_valid_q;
        wb_err   = wb_err_q;
        misalign = misalign_q;
        wb_rdata = wb_rdata_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected bus requests and writebacks are queued by the stimulus
// and compared by a monitor branch whenever the DUT presents mem_req or wb_valid.
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        wb_err;
    logic        misalign;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(stall),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_err(wb_err), .misalign(misalign)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mis;
        int          due;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   n_tests;
    int   n_fails;
    int   cyc_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and play the memory side; bus=0 means no bus access is expected.
    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input int gdly, input logic [31:0] rd, input logic bus,
                      input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd,
                      input logic [31:0] erd, input logic eerr, input logic emis);
        bus_t b;
        wb_t  w;
        int   c;
        c = cyc_n;
        if (bus) begin
            b.addr = eaddr; b.we = we; b.be = ebe; b.wd = ewd;
            bus_q.push_back(b);
        end
        w.rd = erd; w.err = eerr; w.mis = emis;
        w.due = bus ? c + 3 + gdly : c + 1;
        wb_q.push_back(w);
        ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = a; ex_wdata = d;
        cyc();
        ex_valid = 1'b0;
        if (bus) begin
            repeat (gdly) cyc();
            mem_gnt = 1'b1;
            cyc();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = rd;
            cyc();
            mem_rvalid = 1'b0;
        end
        cyc();
    endtask

    initial begin
        bus_t b;
        wb_t  w;
        int   c;
        n_tests = 0; n_fails = 0; cyc_n = 0;
        reset = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rdata", wb_rdata, 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);

        fork
            forever begin
                @(negedge clk);
                if (mem_req) begin
                    chk("req_stall", 32'(stall), 32'd1);
                    chk("req_ex_ready", 32'(ex_ready), 32'd0);
                    if (bus_q.size() == 0) begin
                        n_tests++;
                        n_fails++;
                        $display("FAIL bus_unexpected: mem_req=1 addr %h, no request expected", mem_addr);
                    end else begin
                        chk("mem_addr", mem_addr, bus_q[0].addr);
                        chk("mem_we", 32'(mem_we), 32'(bus_q[0].we));
                        chk("mem_be", 32'(mem_be), 32'(bus_q[0].be));
                        chk("mem_wdata", mem_wdata, bus_q[0].wd);
                        if (mem_gnt) void'(bus_q.pop_front());
                    end
                end
                if (wb_valid) begin
                    if (wb_q.size() == 0) begin
                        n_tests++;
                        n_fails++;
                        $display("FAIL wb_unexpected: wb_valid=1 rdata %h err %0d, none expected", wb_rdata, wb_err);
                    end else begin
                        w = wb_q.pop_front();
                        chk("wb_rdata", wb_rdata, w.rd);
                        chk("wb_err", 32'(wb_err), 32'(w.err));
                        chk("misalign", 32'(misalign), 32'(w.mis));
                        chk("wb_latency", cyc_n, w.due);
                    end
                end
            end
        join_none

        // LB 0x1003: lane 3 = 0x80 sign-extended
        op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_FF00, 1'b1,
           32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
        // SH 0x2002
        op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 32'hDEAD_BEEF, 1'b1,
           32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0);
        // LHU 0x0 with grant held off 5 cycles
        op(1'b0, 3'b101, 32'h0000_0000, 32'h0, 5, 32'h0000_8001, 1'b1,
           32'h0000_0000, 4'b0011, 32'h0, 32'h0000_8001, 1'b0, 1'b0);
        // LH 0x2: upper half 0x8001 sign-extended
        op(1'b0, 3'b001, 32'h0000_0002, 32'h0, 1, 32'h8001_1234, 1'b1,
           32'h0000_0000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0);
        // LBU 0x101: lane 1 = 0x9A zero-extended
        op(1'b0, 3'b100, 32'h0000_0101, 32'h0, 0, 32'h0000_9A00, 1'b1,
           32'h0000_0100, 4'b0010, 32'h0, 32'h0000_009A, 1'b0, 1'b0);
        // LW 0x40
        op(1'b0, 3'b010, 32'h0000_0040, 32'h0, 2, 32'hCAFE_F00D, 1'b1,
           32'h0000_0040, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        // SB 0x11
        op(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 0, 32'h0, 1'b1,
           32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
        // SW 0x20
        op(1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 0, 32'h0, 1'b1,
           32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
        // Illegal load funct3=011 and illegal store funct3=100
        op(1'b0, 3'b011, 32'h0000_1000, 32'h0, 0, 32'h0, 1'b0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        op(1'b1, 3'b100, 32'h0000_1000, 32'h5555_5555, 0, 32'h0, 1'b0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        op(1'b0, 3'b010, 32'h0000_1002, 32'h0, 0, 32'h0, 1'b0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        op(1'b0, 3'b001, 32'h0000_2003, 32'h0, 0, 32'h0, 1'b0,
           32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b1);
`else
        op(1'b0, 3'b010, 32'h0000_1002, 32'h0, 0, 32'h55AA_55AA, 1'b1,
           32'h0000_1000, 4'b1111, 32'h0, 32'h55AA_55AA, 1'b0, 1'b0);
        op(1'b0, 3'b001, 32'h0000_2003, 32'h0, 0, 32'h7FFF_0000, 1'b1,
           32'h0000_2000, 4'b1100, 32'h0, 32'h0000_7FFF, 1'b0, 1'b0);
`endif

        // Timeout: grant, then no rvalid for 4 WAIT cycles; late rvalid must be ignored
        c = cyc_n;
        b.addr = 32'h0000_3000; b.we = 1'b0; b.be = 4'b1111; b.wd = 32'h0;
        bus_q.push_back(b);
        w.rd = 32'h0; w.err = 1'b1; w.mis = 1'b0; w.due = c + 6;
        wb_q.push_back(w);
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_3000; ex_wdata = 32'h0;
        cyc();
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        repeat (4) cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        cyc();
        mem_rvalid = 1'b0;
        repeat (2) cyc();

        // Reset while in WAIT
        b.addr = 32'h0000_4000; b.we = 1'b0; b.be = 4'b1111; b.wd = 32'h0;
        bus_q.push_back(b);
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_4000; ex_wdata = 32'h0;
        cyc();
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        chk("wait_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstwait_ex_ready", 32'(ex_ready), 32'd1);
        chk("rstwait_mem_req", 32'(mem_req), 32'd0);
        chk("rstwait_stall", 32'(stall), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        cyc();
        mem_rvalid = 1'b0;
        chk("late_rvalid_wb", 32'(wb_valid), 32'd0);
        repeat (3) cyc();

        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
